// File: rtl/mandel_pkg.sv
// Shared defaults and pipeline-word field layout for the mandelbrot frame buffer.
package mandel_pkg;

  localparam int RESX_D = 32;
  localparam int RESY_D = 32;
  localparam int PW_D   = 81;
  localparam int CW_D   = 11;
  localparam int IMAX_D = 16;

  // Iteration count lives in the low bits of the pipeline word.
  localparam int ITER_LSB = 0;
  localparam int ITER_W   = 16;

  // Address width that never collapses to zero for tiny arrays.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mandel_fb_ram.sv
// Frame-buffer array: one sync write port, one async read port (recirculation)
// and one registered read port that returns only the iteration field.
module mandel_fb_ram
  import mandel_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int PW    = 81,
  localparam int AW   = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PW-1:0]     wdata,
  input  logic [AW-1:0]     aaddr,
  output logic [PW-1:0]     adata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [ITER_W-1:0] riter
);

  logic [PW-1:0] mem [DEPTH];

  // Synchronous write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Async read sees pre-edge contents on a same-address write.
  assign adata = mem[aaddr];

  // Registered read of the iteration field only.
  always_ff @(posedge clk) begin
    if (re) riter <= mem[raddr][ITER_LSB +: ITER_W];
  end

endmodule

// File: rtl/mandel_fb_collector.sv
// Frame collector: raster-order capture of finished pixels, recirculation of
// the previous frame to the core, and a one-cycle-latency pixel read port.
module mandel_fb_collector
  import mandel_pkg::*;
#(
  parameter int RESX = RESX_D,
  parameter int RESY = RESY_D,
  parameter int PW   = PW_D,
  parameter int CW   = CW_D,
  parameter int IMAX = IMAX_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          output_ready,
  input  logic [PW-1:0] pout,
  input  logic [CW-1:0] xin,
  input  logic [CW-1:0] yin,
  output logic [PW-1:0] pin,
  output logic          fb_init,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  input  logic          rd_req,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output logic          rd_valid,
  output logic [15:0]   rd_iter,
  output logic          rd_written
);

  localparam int DEPTH = RESX * RESY;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int XW    = clog2_min1(RESX);
  localparam int YW    = clog2_min1(RESY);

  logic [XW-1:0]     xout;
  logic [YW-1:0]     yout;
  logic [DEPTH-1:0]  written;
  logic [AW-1:0]     waddr, paddr, raddr;
  logic [PW-1:0]     pword;
  logic [ITER_W-1:0] riter;
  logic              pin_inr, rd_inr, x_last, y_last, rd_re;

  // Linear address for an in-range coordinate pair.
  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(y) * AW'(RESX) + AW'(x);
  endfunction

  assign pin_inr = (32'(xin) < RESX) && (32'(yin) < RESY);
  assign rd_inr  = (32'(rd_x) < RESX) && (32'(rd_y) < RESY);
  assign paddr   = pin_inr ? pix_addr(xin, yin) : '0;
  assign raddr   = rd_inr ? pix_addr(rd_x, rd_y) : '0;
  assign waddr   = AW'(yout) * AW'(RESX) + AW'(xout);
  assign x_last  = (xout == XW'(RESX - 1));
  assign y_last  = (yout == YW'(RESY - 1));
  assign rd_re   = rd_req && rd_inr;

  mandel_fb_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk   (clk),
    .we    (output_ready),
    .waddr (waddr),
    .wdata (pout),
    .aaddr (paddr),
    .adata (pword),
    .re    (rd_re),
    .raddr (raddr),
    .riter (riter)
  );

  // Nothing is recirculated until a whole frame exists.
  assign pin = (fb_init && pin_inr) ? pword : '0;

  // Raster write counters, written mask and frame bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xout       <= '0;
      yout       <= '0;
      fb_init    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      written    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (output_ready) begin
        written[waddr] <= 1'b1;
        if (x_last) begin
          xout <= '0;
          if (y_last) begin
            yout       <= '0;
            fb_init    <= 1'b1;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            yout <= yout + 1'b1;
          end
        end else begin
          xout <= xout + 1'b1;
        end
      end
    end
  end

  // Read-port status; written bit sampled pre-edge so it matches the RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      rd_written <= 1'b0;
    end else begin
      rd_valid   <= rd_req;
      rd_written <= rd_re && written[raddr];
    end
  end

  // Unwritten or out-of-range pixels report the iteration ceiling.
  assign rd_iter = rd_written ? riter : (rd_valid ? 16'(IMAX) : 16'd0);

endmodule

// File: tb/tb_mandel_fb_collector.sv
// Bench for mandel_fb_collector: behavioural frame-buffer model, randomized
// traffic, a read table after the first frame and hand-written corner cases.
module tb_mandel_fb_collector;

  localparam int RESX = 32, RESY = 32, PW = 81, CW = 11, IMAX = 16;
  localparam int N = RESX * RESY;

  logic          clk = 1'b0, rst_n = 1'b0, output_ready = 1'b0, rd_req = 1'b0;
  logic [PW-1:0] pout = '0, pin;
  logic [CW-1:0] xin = '0, yin = '0, rd_x = '0, rd_y = '0;
  logic          fb_init, frame_done, rd_valid, rd_written;
  logic [15:0]   frame_cnt, rd_iter;

  always #5 clk = ~clk;

  mandel_fb_collector dut (
    .clk(clk), .rst_n(rst_n), .output_ready(output_ready), .pout(pout),
    .xin(xin), .yin(yin), .pin(pin), .fb_init(fb_init), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_iter(rd_iter), .rd_written(rd_written)
  );

  int total = 0, bad = 0;

  // Reference model: flat pixel store, written flags, linear write index.
  logic [PW-1:0] mem_m [N];
  bit            wr_m  [N];
  int            widx = 0, fcnt = 0, fd_seen = 0;
  bit            fb_m = 0, fd_m = 0, rv_m = 0, rw_m = 0;
  logic [15:0]   ri_m = '0;

  typedef struct { int rx; int ry; logic [15:0] iter; logic wr; } rvec_t;
  rvec_t tbl [9];

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rword();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  // One clock: drive, check pin before the edge, advance model, check after.
  task automatic cyc(input bit ordy, input logic [PW-1:0] po, input int xi, input int yi,
                     input bit rq, input int rx, input int ry);
    int a;
    output_ready = ordy; pout = po; xin = CW'(xi); yin = CW'(yi);
    rd_req = rq; rd_x = CW'(rx); rd_y = CW'(ry);
    @(negedge clk);
    if (fb_m && xi < RESX && yi < RESY) chk("pin", pin, mem_m[yi*RESX + xi]);
    else chk("pin_zero", pin, '0);
    rv_m = rq; rw_m = 0; ri_m = 16'(IMAX);
    if (rq && rx < RESX && ry < RESY) begin
      a = ry*RESX + rx;
      rw_m = wr_m[a];
      if (rw_m) ri_m = mem_m[a][15:0];
    end
    fd_m = 0;
    if (ordy) begin
      mem_m[widx] = po; wr_m[widx] = 1; widx++;
      if (widx == N) begin widx = 0; fb_m = 1; fcnt = (fcnt + 1) % 65536; fd_m = 1; end
    end
    @(posedge clk); #1;
    chk("rd_valid", PW'(rd_valid), PW'(rv_m));
    if (rv_m) begin
      chk("rd_iter", PW'(rd_iter), PW'(ri_m));
      chk("rd_written", PW'(rd_written), PW'(rw_m));
    end
    chk("frame_done", PW'(frame_done), PW'(fd_m));
    chk("fb_init", PW'(fb_init), PW'(fb_m));
    chk("frame_cnt", PW'(frame_cnt), PW'(fcnt));
    if (frame_done) fd_seen++;
  endtask

  // Async reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; output_ready = 1'b0; rd_req = 1'b0;
    #1;
    chk("rst_fb_init", PW'(fb_init), '0);
    chk("rst_frame_done", PW'(frame_done), '0);
    chk("rst_frame_cnt", PW'(frame_cnt), '0);
    chk("rst_rd_valid", PW'(rd_valid), '0);
    chk("rst_rd_iter", PW'(rd_iter), '0);
    chk("rst_rd_written", PW'(rd_written), '0);
    widx = 0; fb_m = 0; fcnt = 0;
    for (int i = 0; i < N; i++) wr_m[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] w, w34, oldw, neww, w0;
    int start;

    tbl[0] = '{5, 7, 16'd12, 1'b1};
    tbl[1] = '{0, 0, 16'd0, 1'b1};
    tbl[2] = '{31, 31, 16'd62, 1'b1};
    tbl[3] = '{17, 3, 16'd20, 1'b1};
    tbl[4] = '{31, 0, 16'd31, 1'b1};
    tbl[5] = '{0, 31, 16'd31, 1'b1};
    tbl[6] = '{40, 2, 16'd16, 1'b0};
    tbl[7] = '{2, 40, 16'd16, 1'b0};
    tbl[8] = '{32, 0, 16'd16, 1'b0};
    for (int i = 0; i < N; i++) mem_m[i] = '0;
    w34 = '0;

    do_reset();

    // Reads before any write: ceiling, not written.
    cyc(0, '0, 3, 4, 1, 0, 0);
    chk("pre_rd00_iter", PW'(rd_iter), PW'(IMAX));
    chk("pre_rd00_wr", PW'(rd_written), '0);
    cyc(0, '0, 3, 4, 1, 40, 2);
    chk("pre_rd40_iter", PW'(rd_iter), PW'(IMAX));
    chk("pre_rd40_wr", PW'(rd_written), '0);

    // Frame 1: iter = x+y, gap of 10 idle cycles at (17,3), random reads.
    fd_seen = 0;
    for (int y = 0; y < RESY; y++)
      for (int x = 0; x < RESX; x++) begin
        if (y == 3 && x == 17)
          for (int g = 0; g < 10; g++)
            cyc(0, rword(), 3, 4, 1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 40));
        w = rword(); w[15:0] = 16'(x + y);
        if (x == 3 && y == 4) w34 = w;
        cyc(1, w, 3, 4, 1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 40));
      end
    chk("frame1_pulses", PW'(fd_seen), PW'(1));

    cyc(0, '0, 3, 4, 0, 0, 0);
    chk("pin34_after_frame", pin, w34);

    for (int i = 0; i < 9; i++) begin
      cyc(0, '0, 0, 0, 1, tbl[i].rx, tbl[i].ry);
      chk($sformatf("tbl%0d_iter", i), PW'(rd_iter), PW'(tbl[i].iter));
      chk($sformatf("tbl%0d_wr", i), PW'(rd_written), PW'(tbl[i].wr));
    end

    // Same-cycle write and pin/read of (0,0): old word first, new word next.
    oldw = mem_m[0];
    neww = ~oldw;
    cyc(1, neww, 0, 0, 1, 0, 0);
    chk("same_rd_old", PW'(rd_iter), PW'(oldw[15:0]));
    chk("same_pin_new", pin, neww);

    // Frame 2 random traffic up to pixel (10,20), then reset there.
    for (int k = 0; k < 5000 && widx != 20*RESX + 10; k++)
      cyc($urandom_range(0, 3) != 0, rword(), $urandom_range(0, 40), $urandom_range(0, 40),
          1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 40));
    chk("reach_10_20", PW'(widx), PW'(20*RESX + 10));
    do_reset();

    w0 = rword(); w0[15:0] = 16'h0abc;
    cyc(1, w0, 0, 0, 1, 0, 0);
    chk("post_rst_rd_same", PW'(rd_written), '0);
    cyc(0, '0, 0, 0, 1, 0, 0);
    chk("post_rst_at00_iter", PW'(rd_iter), PW'(16'h0abc));
    chk("post_rst_at00_wr", PW'(rd_written), PW'(1));
    cyc(0, '0, 0, 0, 1, 10, 20);
    chk("post_rst_10_20_wr", PW'(rd_written), '0);
    chk("post_rst_fb_init", PW'(fb_init), '0);

    // Finish a whole frame after reset with random traffic.
    start = fd_seen;
    for (int k = 0; k < 5000 && fd_seen == start; k++)
      cyc($urandom_range(0, 3) != 0, rword(), $urandom_range(0, 40), $urandom_range(0, 40),
          1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 40));
    chk("frame_after_reset", PW'(fd_seen - start), PW'(1));
    chk("final_fb_init", PW'(fb_init), PW'(1));
    chk("final_frame_cnt", PW'(frame_cnt), PW'(1));
    for (int k = 0; k < 20; k++)
      cyc(0, '0, $urandom_range(0, 40), $urandom_range(0, 40), 1, $urandom_range(0, 40), $urandom_range(0, 40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
